// File: rtl/sram_dp_model.sv
// ---------------------------------------------------------------------------
// sram_dp_model
//   Behavioural dual-port SRAM responder for the Mem2FIFO SRAM-side bus.
//   It stands in for the hard macro in simulation and in FPGA builds.
//   Features: byte-masked writes, a read latency of 1 or 2 cycles, a fixed
//   cross-port collision policy and a registered collision flag.
//
// Parameters
//   WIDTH       word width in bits (multiple of 8)
//   DEPTH       number of words
//   READ_LAT    read latency in cycles (1 or 2)
//   WRITE_FIRST 1: a cross-port read of a word being written returns the
//                  merged new word; 0: it returns the old word
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ce_x, addr_x, we_x,         per-port chip enable, word address,
//   wmask_x, wdata_x            write enable, byte write mask, write data
//   rdata_x                     per-port read data (holds until next read)
//   collision                   one-cycle pulse after a same-address cycle
//                               in which at least one port wrote
// ---------------------------------------------------------------------------
module sram_dp_model #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 16,
   parameter int READ_LAT    = 1,
   parameter int WRITE_FIRST = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ce_a,
   input  logic [$clog2(DEPTH)-1:0] addr_a,
   input  logic                     we_a,
   input  logic [WIDTH/8-1:0]       wmask_a,
   input  logic [WIDTH-1:0]         wdata_a,
   output logic [WIDTH-1:0]         rdata_a,
   input  logic                     ce_b,
   input  logic [$clog2(DEPTH)-1:0] addr_b,
   input  logic                     we_b,
   input  logic [WIDTH/8-1:0]       wmask_b,
   input  logic [WIDTH-1:0]         wdata_b,
   output logic [WIDTH-1:0]         rdata_b,
   output logic                     collision
);

   localparam int AW = $clog2(DEPTH);
   localparam int NB = WIDTH / 8;

   // Parameter sanity: stop elaboration on configurations we cannot build.
   if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $fatal(1, "sram_dp_model: WIDTH must be a non-zero multiple of 8");
   end
   if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $fatal(1, "sram_dp_model: READ_LAT must be 1 or 2");
   end

   // Both ports gathered into index-0 = A, index-1 = B vectors so the
   // per-port logic below can be written once.
   logic [1:0]            ce;
   logic [1:0]            we;
   logic [1:0]            in_range;
   logic [1:0]            wr_en;
   logic [1:0]            rd_en;
   logic [1:0][AW-1:0]    addr;
   logic [1:0][NB-1:0]    wmask;
   logic [1:0][WIDTH-1:0] wdata;

   assign ce    = {ce_b, ce_a};
   assign we    = {we_b, we_a};
   assign addr  = {addr_b, addr_a};
   assign wmask = {wmask_b, wmask_a};
   assign wdata = {wdata_b, wdata_a};

   // Addresses can only exceed DEPTH-1 when DEPTH is not a power of two.
   if (DEPTH == (1 << AW)) begin : g_pow2
      assign in_range = 2'b11;
   end else begin : g_npow2
      assign in_range = {(32'(addr_b) < DEPTH), (32'(addr_a) < DEPTH)};
   end

   assign wr_en = ce & we & in_range;
   assign rd_en = ce & ~we;

   // Storage: deliberately not reset so contents survive rst_n.
   logic [WIDTH-1:0] mem [DEPTH];

   // Port A is applied last so it wins on bytes both ports write.
   always_ff @(posedge clk) begin : p_mem_write
      for (int i = 0; i < NB; i++) begin
         if (wr_en[1] && wmask[1][i]) mem[addr[1]][8*i +: 8] <= wdata[1][8*i +: 8];
         if (wr_en[0] && wmask[0][i]) mem[addr[0]][8*i +: 8] <= wdata[0][8*i +: 8];
      end
   end

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_port
      localparam int OTH = 1 - gi;

      logic [WIDTH-1:0] rd_word_d;
      logic [WIDTH-1:0] rdata_q;

      // Word captured by a read at this edge. The array read sees the
      // pre-edge contents; with WRITE_FIRST the other port's masked bytes
      // are merged in so the reader observes the post-write word.
      always_comb begin
         rd_word_d = '0;
         if (in_range[gi]) begin
            rd_word_d = mem[addr[gi]];
            if (WRITE_FIRST != 0 && wr_en[OTH] && (addr[OTH] == addr[gi])) begin
               for (int i = 0; i < NB; i++) begin
                  if (wmask[OTH][i]) rd_word_d[8*i +: 8] = wdata[OTH][8*i +: 8];
               end
            end
         end
      end

      if (READ_LAT == 1) begin : g_lat1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata_q <= '0;
            end else if (rd_en[gi]) begin
               rdata_q <= rd_word_d;
            end
         end
      end else begin : g_lat2
         logic [WIDTH-1:0] rd1_q;
         logic             rd1_vld_q;

         // First stage tracks whether a read is in flight; the output
         // register only moves when a valid read reaches it, which keeps
         // the hold rule and lets reset discard in-flight reads.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd1_q     <= '0;
               rd1_vld_q <= 1'b0;
               rdata_q   <= '0;
            end else begin
               rd1_vld_q <= rd_en[gi];
               if (rd_en[gi]) rd1_q <= rd_word_d;
               if (rd1_vld_q) rdata_q <= rd1_q;
            end
         end
      end
   end

   assign rdata_a = g_port[0].rdata_q;
   assign rdata_b = g_port[1].rdata_q;

   // Equal addresses imply equal range status, so one in_range bit suffices.
   logic collision_q;
   logic collision_d;

   assign collision_d = ce[0] & ce[1] & (addr[0] == addr[1]) & (we[0] | we[1]) & in_range[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collision_q <= 1'b0;
      end else begin
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;

endmodule

// File: tb/tb_sram_dp_model.sv
// ---------------------------------------------------------------------------
// tb_sram_dp_model
//   Drives four configurations of sram_dp_model from one shared stimulus:
//     inst 0: READ_LAT=1 WRITE_FIRST=0 DEPTH=16
//     inst 1: READ_LAT=2 WRITE_FIRST=0 DEPTH=16
//     inst 2: READ_LAT=1 WRITE_FIRST=1 DEPTH=16
//     inst 3: READ_LAT=2 WRITE_FIRST=1 DEPTH=12 (out-of-range addresses)
//   Directed scenarios check fixed expected words; the random scenario checks
//   every cycle against a word-level memory model with a per-port queue of
//   read results, each due READ_LAT-1 edges after issue.
// ---------------------------------------------------------------------------
module tb_sram_dp_model;

   localparam int LAT_P [4] = '{1, 2, 1, 2};
   localparam int WF_P  [4] = '{0, 0, 1, 1};
   localparam int DEP_P [4] = '{16, 16, 16, 12};

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        ce_a, we_a, ce_b, we_b;
   logic [3:0]  addr_a, addr_b;
   logic [1:0]  wmask_a, wmask_b;
   logic [15:0] wdata_a, wdata_b;
   logic [15:0] rdata_a_o [4];
   logic [15:0] rdata_b_o [4];
   logic        col_o [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_dp_model #(.WIDTH(16), .DEPTH(16), .READ_LAT(1), .WRITE_FIRST(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .ce_a(ce_a), .addr_a(addr_a), .we_a(we_a), .wmask_a(wmask_a), .wdata_a(wdata_a), .rdata_a(rdata_a_o[0]),
      .ce_b(ce_b), .addr_b(addr_b), .we_b(we_b), .wmask_b(wmask_b), .wdata_b(wdata_b), .rdata_b(rdata_b_o[0]),
      .collision(col_o[0]));

   sram_dp_model #(.WIDTH(16), .DEPTH(16), .READ_LAT(2), .WRITE_FIRST(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .ce_a(ce_a), .addr_a(addr_a), .we_a(we_a), .wmask_a(wmask_a), .wdata_a(wdata_a), .rdata_a(rdata_a_o[1]),
      .ce_b(ce_b), .addr_b(addr_b), .we_b(we_b), .wmask_b(wmask_b), .wdata_b(wdata_b), .rdata_b(rdata_b_o[1]),
      .collision(col_o[1]));

   sram_dp_model #(.WIDTH(16), .DEPTH(16), .READ_LAT(1), .WRITE_FIRST(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .ce_a(ce_a), .addr_a(addr_a), .we_a(we_a), .wmask_a(wmask_a), .wdata_a(wdata_a), .rdata_a(rdata_a_o[2]),
      .ce_b(ce_b), .addr_b(addr_b), .we_b(we_b), .wmask_b(wmask_b), .wdata_b(wdata_b), .rdata_b(rdata_b_o[2]),
      .collision(col_o[2]));

   sram_dp_model #(.WIDTH(16), .DEPTH(12), .READ_LAT(2), .WRITE_FIRST(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .ce_a(ce_a), .addr_a(addr_a), .we_a(we_a), .wmask_a(wmask_a), .wdata_a(wdata_a), .rdata_a(rdata_a_o[3]),
      .ce_b(ce_b), .addr_b(addr_b), .we_b(we_b), .wmask_b(wmask_b), .wdata_b(wdata_b), .rdata_b(rdata_b_o[3]),
      .collision(col_o[3]));

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [15:0] val;
   } rd_t;

   logic [15:0] ref_mem [16];
   rd_t         pipe_q  [8][$];   // index inst*2+port
   logic [15:0] exp_rd  [8];
   logic        exp_col [4];
   int          edge_cnt = 0;

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         pipe_q[k].delete();
         exp_rd[k] = 16'h0000;
      end
      for (int i = 0; i < 4; i++) exp_col[i] = 1'b0;
   endtask

   task automatic drive(input logic cea, input logic wea, input logic [3:0] aa,
                        input logic [1:0] ma, input logic [15:0] da,
                        input logic ceb, input logic web, input logic [3:0] ab,
                        input logic [1:0] mb, input logic [15:0] db);
      ce_a = cea; we_a = wea; addr_a = aa; wmask_a = ma; wdata_a = da;
      ce_b = ceb; we_b = web; addr_b = ab; wmask_b = mb; wdata_b = db;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
   endtask

   // One clock: apply the edge to the model, then return at the falling edge.
   task automatic step();
      logic        pce [2];
      logic        pwe [2];
      logic [3:0]  pad [2];
      logic [1:0]  pmk [2];
      logic [15:0] pdt [2];
      logic [15:0] val;
      rd_t         r;
      int          o;
      pce[0] = ce_a; pwe[0] = we_a; pad[0] = addr_a; pmk[0] = wmask_a; pdt[0] = wdata_a;
      pce[1] = ce_b; pwe[1] = we_b; pad[1] = addr_b; pmk[1] = wmask_b; pdt[1] = wdata_b;
      @(posedge clk);
      edge_cnt++;
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            exp_col[i] = pce[0] && pce[1] && (pad[0] == pad[1]) && (pwe[0] || pwe[1])
                         && (int'(pad[0]) < DEP_P[i]);
            for (int p = 0; p < 2; p++) begin
               o = 1 - p;
               if (pce[p] && !pwe[p]) begin
                  val = (int'(pad[p]) < DEP_P[i]) ? ref_mem[pad[p]] : 16'h0000;
                  if (WF_P[i] == 1 && pce[o] && pwe[o] && pad[o] == pad[p] && int'(pad[p]) < DEP_P[i]) begin
                     if (pmk[o][0]) val[7:0]  = pdt[o][7:0];
                     if (pmk[o][1]) val[15:8] = pdt[o][15:8];
                  end
                  r.due = edge_cnt + LAT_P[i] - 1;
                  r.val = val;
                  pipe_q[i*2+p].push_back(r);
               end
               while (pipe_q[i*2+p].size() > 0 && pipe_q[i*2+p][0].due <= edge_cnt) begin
                  r = pipe_q[i*2+p].pop_front();
                  exp_rd[i*2+p] = r.val;
               end
            end
         end
      end
      // Memory update: A's masked bytes; B's bytes only where A did not write.
      for (int b = 0; b < 2; b++) begin
         if (ce_a_w(pce[0], pwe[0]) && pmk[0][b])
            ref_mem[pad[0]][8*b +: 8] = pdt[0][8*b +: 8];
         if (ce_a_w(pce[1], pwe[1]) && pmk[1][b] &&
             !(ce_a_w(pce[0], pwe[0]) && pad[0] == pad[1] && pmk[0][b]))
            ref_mem[pad[1]][8*b +: 8] = pdt[1][8*b +: 8];
      end
      @(negedge clk);
   endtask

   function automatic logic ce_a_w(input logic c, input logic w);
      return c && w;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== 16'h0 || rdata_b_o[i] !== 16'h0 || col_o[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async inst%0d: got a=%h b=%h col=%b want 0/0/0", i, rdata_a_o[i], rdata_b_o[i], col_o[i]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), 2'b11, 16'h0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 2'b11, 16'h0);
         step();
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdata_a_o[i] !== 16'h0 || rdata_b_o[i] !== 16'h0 || col_o[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_hold inst%0d cyc%0d: got a=%h b=%h col=%b want 0/0/0", i, c, rdata_a_o[i], rdata_b_o[i], col_o[i]);
            end
         end
      end
      idle();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== 16'h0 || rdata_b_o[i] !== 16'h0 || col_o[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release inst%0d: got a=%h b=%h col=%b want 0/0/0", i, rdata_a_o[i], rdata_b_o[i], col_o[i]);
         end
      end
   endtask

   task automatic test_basic_latency();
      drive(1'b1, 1'b1, 4'd3, 2'b11, 16'hBEEF, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      drive(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 1'b0, 4'd3, 2'b00, 16'h0);
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_b_o[i] !== ((LAT_P[i] == 1) ? 16'hBEEF : 16'h0000)) begin
            n_fail++;
            $display("FAIL basic_first_cycle inst%0d: got %h want %h", i, rdata_b_o[i], (LAT_P[i] == 1) ? 16'hBEEF : 16'h0000);
         end
      end
      for (int c = 0; c < 4; c++) begin
         step();
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdata_b_o[i] !== 16'hBEEF) begin
               n_fail++;
               $display("FAIL basic_hold inst%0d cyc%0d: got %h want BEEF", i, c, rdata_b_o[i]);
            end
         end
      end
   endtask

   task automatic test_byte_mask();
      drive(1'b1, 1'b1, 4'd5, 2'b11, 16'h1234, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      drive(1'b1, 1'b1, 4'd5, 2'b10, 16'hABCD, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== 16'h0000) begin
            n_fail++;
            $display("FAIL write_no_disturb inst%0d: got %h want 0000", i, rdata_a_o[i]);
         end
      end
      drive(1'b1, 1'b0, 4'd5, 2'b00, 16'h0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      idle();
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== 16'hAB34) begin
            n_fail++;
            $display("FAIL byte_mask inst%0d: got %h want AB34", i, rdata_a_o[i]);
         end
      end
   endtask

   task automatic test_collision();
      logic [15:0] want;
      drive(1'b1, 1'b1, 4'd7, 2'b11, 16'h0000, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      drive(1'b1, 1'b1, 4'd7, 2'b11, 16'h5555, 1'b1, 1'b0, 4'd7, 2'b00, 16'h0);
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (col_o[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_collision_set inst%0d: got %b want 1", i, col_o[i]);
         end
      end
      step();
      for (int i = 0; i < 4; i++) begin
         want = (WF_P[i] == 1) ? 16'h5555 : 16'h0000;
         n_checks++;
         if (col_o[i] !== 1'b0 || rdata_b_o[i] !== want) begin
            n_fail++;
            $display("FAIL wr_rd_collision inst%0d: got col=%b b=%h want col=0 b=%h", i, col_o[i], rdata_b_o[i], want);
         end
      end
      drive(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 1'b0, 4'd7, 2'b00, 16'h0);
      step();
      idle();
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_b_o[i] !== 16'h5555) begin
            n_fail++;
            $display("FAIL collision_readback inst%0d: got %h want 5555", i, rdata_b_o[i]);
         end
      end
   endtask

   task automatic test_double_write();
      drive(1'b1, 1'b1, 4'd9, 2'b01, 16'h1111, 1'b1, 1'b1, 4'd9, 2'b11, 16'h2222);
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (col_o[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL dbl_write_col_set inst%0d: got %b want 1", i, col_o[i]);
         end
      end
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (col_o[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL dbl_write_col_clear inst%0d: got %b want 0", i, col_o[i]);
         end
      end
      drive(1'b1, 1'b0, 4'd9, 2'b00, 16'h0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      idle();
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== 16'h2211) begin
            n_fail++;
            $display("FAIL dbl_write_data inst%0d: got %h want 2211", i, rdata_a_o[i]);
         end
      end
   endtask

   task automatic test_out_of_range();
      drive(1'b1, 1'b1, 4'd13, 2'b11, 16'h7777, 1'b1, 1'b1, 4'd13, 2'b11, 16'h1234);
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (col_o[i] !== ((DEP_P[i] > 13) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL oor_collision inst%0d: got %b want %b", i, col_o[i], (DEP_P[i] > 13) ? 1'b1 : 1'b0);
         end
      end
      drive(1'b1, 1'b0, 4'd13, 2'b00, 16'h0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      idle();
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== ((DEP_P[i] > 13) ? 16'h7777 : 16'h0000)) begin
            n_fail++;
            $display("FAIL oor_read inst%0d: got %h want %h", i, rdata_a_o[i], (DEP_P[i] > 13) ? 16'h7777 : 16'h0000);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      drive(1'b1, 1'b1, 4'd2, 2'b11, 16'h00AA, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      drive(1'b1, 1'b0, 4'd2, 2'b00, 16'h0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         if (LAT_P[i] == 2) begin
            n_checks++;
            if (rdata_a_o[i] === 16'h00AA) begin
               n_fail++;
               $display("FAIL midread_early inst%0d: got %h want not 00AA", i, rdata_a_o[i]);
            end
         end
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== 16'h0000) begin
            n_fail++;
            $display("FAIL midread_async_clear inst%0d: got %h want 0000", i, rdata_a_o[i]);
         end
      end
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== 16'h0000) begin
            n_fail++;
            $display("FAIL midread_discard inst%0d: got %h want 0000", i, rdata_a_o[i]);
         end
      end
      drive(1'b1, 1'b0, 4'd2, 2'b00, 16'h0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
      step();
      idle();
      step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rdata_a_o[i] !== 16'h00AA) begin
            n_fail++;
            $display("FAIL midread_preserved inst%0d: got %h want 00AA", i, rdata_a_o[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int a = 0; a < 16; a++) begin
         drive(1'b1, 1'b1, 4'(a), 2'b11, 16'($urandom), 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
         step();
      end
      for (int c = 0; c < 300; c++) begin
         // Narrow address range so collisions and merges happen often.
         drive(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 15) & ((c % 2 == 0) ? 15 : 3) | ((c % 4 == 1) ? 12 : 0)),
               2'($urandom), 16'($urandom),
               ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 15) & ((c % 2 == 0) ? 15 : 3) | ((c % 4 == 1) ? 12 : 0)),
               2'($urandom), 16'($urandom));
         step();
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdata_a_o[i] !== exp_rd[i*2] || rdata_b_o[i] !== exp_rd[i*2+1] || col_o[i] !== exp_col[i]) begin
               n_fail++;
               $display("FAIL random inst%0d cyc%0d: got a=%h b=%h col=%b want a=%h b=%h col=%b",
                        i, c, rdata_a_o[i], rdata_b_o[i], col_o[i], exp_rd[i*2], exp_rd[i*2+1], exp_col[i]);
            end
         end
      end
      idle();
   endtask

   initial begin
      idle();
      for (int k = 0; k < 16; k++) ref_mem[k] = 16'h0000;
      model_reset();
      test_reset();
      test_basic_latency();
      test_byte_mask();
      test_collision();
      test_double_write();
      test_out_of_range();
      test_reset_mid_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
